// File: rtl/draw_pkg.sv
// draw_pkg: definitions shared by the VGA rectangle-draw arbiter.
//   SCREEN_W / SCREEN_H  visible area of the 160x120 adapter
//   DRAW_*_W             default coordinate and colour widths
//   state_e              draw FSM states
//   idx_width()          width of a requester index (at least 1 bit)
package draw_pkg;

  localparam int SCREEN_W     = 160;
  localparam int SCREEN_H     = 120;
  localparam int DRAW_X_W     = 8;
  localparam int DRAW_Y_W     = 7;
  localparam int DRAW_COLOR_W = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DRAW = 2'd2,
    DONE = 2'd3
  } state_e;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational requester selection for vga_draw_arbiter.
//   req    request vector
//   ptr    index of the most recently served requester
//   grant  one-hot winner (all zero when no request)
//   idx    index of the winner
// Default: round-robin, first set bit searching from ptr+1 modulo N_REQ.
// With VGA_DRAW_ARB_FIXED_PRIO_EN defined: lowest set index wins, ptr ignored.
module rr_arbiter
  import draw_pkg::*;
#(
  parameter int N_REQ = 3,
  parameter int IDX_W = idx_width(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N_REQ-1:0] grant,
  output logic [IDX_W-1:0] idx
);

  logic found;

`ifdef VGA_DRAW_ARB_FIXED_PRIO_EN
  logic unused_ptr;
  assign unused_ptr = ^ptr;

  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    grant = '0;
    idx   = '0;
    found = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!found && req[k]) begin
        found    = 1'b1;
        grant[k] = 1'b1;
        idx      = IDX_W'(k);
      end
    end
  end
`else
  logic [IDX_W-1:0] cand;

  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    grant = '0;
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    // Candidates in order ptr+1, ptr+2, ..., ptr (wrapping); the pointer itself is tried last.
    for (int off = 1; off <= N_REQ; off++) begin
      cand = IDX_W'((int'(ptr) + off) % N_REQ);
      if (!found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        idx         = cand;
      end
    end
  end
`endif

endmodule

// File: rtl/vga_draw_arbiter.sv
// vga_draw_arbiter: shares the pixel-write port of the 160x120 VGA adapter
// between N_REQ rectangle-drawing requesters. One request is accepted at a
// time, then the rectangle is swept row by row at one pixel per clock.
//   clk, resetn   clock, asynchronous active-low reset
//   req           per-requester level request, held until gnt
//   req_x/y/w/h   per-requester top-left corner and size (slice k)
//   req_color     per-requester fill colour (slice k)
//   gnt           one-hot pulse in LOAD: parameters latched
//   done          one-hot pulse in DONE: rectangle finished
//   busy          high in LOAD, DRAW and DONE
//   vga_x/y/colour/plot  pixel write to the adapter
// Build option: VGA_DRAW_ARB_FIXED_PRIO_EN selects fixed priority (lowest
// index wins) instead of round-robin.
module vga_draw_arbiter
  import draw_pkg::*;
#(
  parameter int N_REQ   = 3,
  parameter int X_W     = DRAW_X_W,
  parameter int Y_W     = DRAW_Y_W,
  parameter int COLOR_W = DRAW_COLOR_W
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic [N_REQ-1:0]           req,
  input  logic [N_REQ*X_W-1:0]       req_x,
  input  logic [N_REQ*Y_W-1:0]       req_y,
  input  logic [N_REQ*X_W-1:0]       req_w,
  input  logic [N_REQ*Y_W-1:0]       req_h,
  input  logic [N_REQ*COLOR_W-1:0]   req_color,
  output logic [N_REQ-1:0]           gnt,
  output logic [N_REQ-1:0]           done,
  output logic                       busy,
  output logic [X_W-1:0]             vga_x,
  output logic [Y_W-1:0]             vga_y,
  output logic [COLOR_W-1:0]         vga_colour,
  output logic                       vga_plot
);

  localparam int IDX_W = idx_width(N_REQ);

  state_e             state;
  logic [IDX_W-1:0]   ptr;
  logic [N_REQ-1:0]   cur_oh;

  // Latched rectangle
  logic [X_W-1:0]     x0, w;
  logic [Y_W-1:0]     y0, h;
  logic [COLOR_W-1:0] col;

  // Column / row of the pixel currently presented
  logic [X_W-1:0]     i;
  logic [Y_W-1:0]     j;

  logic [N_REQ-1:0]   win_oh;
  logic [IDX_W-1:0]   win_idx;

  logic [X_W-1:0]     sel_x, sel_w;
  logic [Y_W-1:0]     sel_y, sel_h;
  logic [COLOR_W-1:0] sel_col;

  logic [X_W-1:0]     nxt_i;
  logic [Y_W-1:0]     nxt_j;
  logic               last_col, last_row;
  logic [X_W:0]       sum_x;
  logic [Y_W:0]       sum_y;
  logic               pix_on;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_arb (
    .req   (req),
    .ptr   (ptr),
    .grant (win_oh),
    .idx   (win_idx)
  );

  // Parameters of the winning requester
  always_comb begin
    sel_x   = '0;
    sel_y   = '0;
    sel_w   = '0;
    sel_h   = '0;
    sel_col = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (win_oh[k]) begin
        sel_x   = req_x[k*X_W +: X_W];
        sel_y   = req_y[k*Y_W +: Y_W];
        sel_w   = req_w[k*X_W +: X_W];
        sel_h   = req_h[k*Y_W +: Y_W];
        sel_col = req_color[k*COLOR_W +: COLOR_W];
      end
    end
  end

  // Next pixel to present: origin when leaving LOAD, else raster step.
  assign last_col = (i == w - X_W'(1));
  assign last_row = (j == h - Y_W'(1));

  always_comb begin
    if (state == LOAD) begin
      nxt_i = '0;
      nxt_j = '0;
    end else if (last_col) begin
      nxt_i = '0;
      nxt_j = j + Y_W'(1);
    end else begin
      nxt_i = i + X_W'(1);
      nxt_j = j;
    end
  end

  // One extra bit so coordinates past the right/bottom edge are not aliased
  // back on screen; the adapter still receives the truncated sum.
  assign sum_x  = {1'b0, x0} + {1'b0, nxt_i};
  assign sum_y  = {1'b0, y0} + {1'b0, nxt_j};
  assign pix_on = (sum_x < (X_W+1)'(SCREEN_W)) && (sum_y < (Y_W+1)'(SCREEN_H));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      // Pointer starts at the last requester so requester 0 wins first.
      state      <= IDLE;
      ptr        <= IDX_W'(N_REQ - 1);
      cur_oh     <= '0;
      x0         <= '0;
      y0         <= '0;
      w          <= '0;
      h          <= '0;
      col        <= '0;
      i          <= '0;
      j          <= '0;
      gnt        <= '0;
      done       <= '0;
      busy       <= 1'b0;
      vga_x      <= '0;
      vga_y      <= '0;
      vga_colour <= '0;
      vga_plot   <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      gnt  <= '0;
      done <= '0;
      case (state)
        IDLE: begin
          if (|req) begin
            x0     <= sel_x;
            y0     <= sel_y;
            w      <= sel_w;
            h      <= sel_h;
            col    <= sel_col;
            cur_oh <= win_oh;
            ptr    <= win_idx;
            gnt    <= win_oh;
            busy   <= 1'b1;
            state  <= LOAD;
          end
        end

        LOAD: begin
          i <= nxt_i;
          j <= nxt_j;
          if (w == '0 || h == '0) begin
            done     <= cur_oh;
            vga_plot <= 1'b0;
            state    <= DONE;
          end else begin
            vga_x      <= sum_x[X_W-1:0];
            vga_y      <= sum_y[Y_W-1:0];
            vga_colour <= col;
            vga_plot   <= pix_on;
            state      <= DRAW;
          end
        end

        DRAW: begin
          if (last_col && last_row) begin
            done     <= cur_oh;
            vga_plot <= 1'b0;
            state    <= DONE;
          end else begin
            i          <= nxt_i;
            j          <= nxt_j;
            vga_x      <= sum_x[X_W-1:0];
            vga_y      <= sum_y[Y_W-1:0];
            vga_colour <= col;
            vga_plot   <= pix_on;
          end
        end

        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vga_draw_arbiter.sv
// tb_vga_draw_arbiter: self-checking bench for vga_draw_arbiter.
// A queue-based model expands every accepted request into the list of
// per-cycle outputs it must produce (grant, pixels in raster order, done)
// and a negedge process compares the DUT against it each cycle. Directed
// scenarios add literal expectations; a random phase follows.
// Honours VGA_DRAW_ARB_FIXED_PRIO_EN like the design.
module tb_vga_draw_arbiter;

  localparam int N  = 3;
  localparam int XW = 8;
  localparam int YW = 7;
  localparam int CW = 3;

  logic            clk = 1'b0;
  logic            resetn;
  logic [N-1:0]    req;
  logic [N*XW-1:0] req_x, req_w;
  logic [N*YW-1:0] req_y, req_h;
  logic [N*CW-1:0] req_color;
  logic [N-1:0]    gnt, done;
  logic            busy;
  logic [XW-1:0]   vga_x;
  logic [YW-1:0]   vga_y;
  logic [CW-1:0]   vga_colour;
  logic            vga_plot;

  int n_cmp  = 0;
  int n_fail = 0;
  bit auto_drop = 1'b0;

  vga_draw_arbiter dut (
    .clk        (clk),
    .resetn     (resetn),
    .req        (req),
    .req_x      (req_x),
    .req_y      (req_y),
    .req_w      (req_w),
    .req_h      (req_h),
    .req_color  (req_color),
    .gnt        (gnt),
    .done       (done),
    .busy       (busy),
    .vga_x      (vga_x),
    .vga_y      (vga_y),
    .vga_colour (vga_colour),
    .vga_plot   (vga_plot)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    logic [N-1:0]  gnt;
    logic [N-1:0]  done;
    logic          busy;
    logic          plot;
    logic          pix;   // x/y/colour meaningful this cycle
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic [CW-1:0] col;
  } exp_t;

  exp_t exp_q[$];
  int   m_ptr;

  function automatic int pick_winner(input logic [N-1:0] r, input int p);
`ifdef VGA_DRAW_ARB_FIXED_PRIO_EN
    for (int k = 0; k < N; k++) if (r[k]) return k;
`else
    for (int off = 1; off <= N; off++) if (r[(p + off) % N]) return (p + off) % N;
`endif
    return -1;
  endfunction

  // Expand the accepted request into its whole output sequence.
  task automatic model_accept();
    int   k, x0, y0, w, h, c;
    exp_t e;
    k  = pick_winner(req, m_ptr);
    x0 = int'(req_x[k*XW +: XW]);
    y0 = int'(req_y[k*YW +: YW]);
    w  = int'(req_w[k*XW +: XW]);
    h  = int'(req_h[k*YW +: YW]);
    c  = int'(req_color[k*CW +: CW]);
    m_ptr = k;
    e = '{default: '0};
    e.gnt  = N'(1 << k);
    e.busy = 1'b1;
    exp_q.push_back(e);
    for (int jj = 0; jj < h; jj++) begin
      for (int ii = 0; ii < w; ii++) begin
        e = '{default: '0};
        e.busy = 1'b1;
        e.pix  = 1'b1;
        e.x    = XW'(x0 + ii);
        e.y    = YW'(y0 + jj);
        e.col  = CW'(c);
        e.plot = (x0 + ii < 160) && (y0 + jj < 120);
        exp_q.push_back(e);
      end
    end
    e = '{default: '0};
    e.done = N'(1 << k);
    e.busy = 1'b1;
    exp_q.push_back(e);
  endtask

  always @(negedge clk) begin : compare
    exp_t e;
    bit   idle_now;
    if (!resetn) begin
      exp_q.delete();
      m_ptr = N - 1;
    end else begin
      idle_now = (exp_q.size() == 0);
      if (idle_now) e = '{default: '0};
      else          e = exp_q.pop_front();
      check("m_gnt",  32'(gnt),      32'(e.gnt));
      check("m_done", 32'(done),     32'(e.done));
      check("m_busy", 32'(busy),     32'(e.busy));
      check("m_plot", 32'(vga_plot), 32'(e.plot));
      if (e.pix) begin
        check("m_x",   32'(vga_x),      32'(e.x));
        check("m_y",   32'(vga_y),      32'(e.y));
        check("m_col", 32'(vga_colour), 32'(e.col));
      end
      if (idle_now && (|req)) model_accept();
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
    if (auto_drop) req = req & ~gnt;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    resetn = 1'b0;
    req    = '0;
    repeat (2) @(posedge clk);
    #2;
    resetn = 1'b1;
  endtask

  task automatic set_par(input int k, input int x, input int y, input int w, input int h, input int c);
    req_x[k*XW +: XW]     = XW'(x);
    req_y[k*YW +: YW]     = YW'(y);
    req_w[k*XW +: XW]     = XW'(w);
    req_h[k*YW +: YW]     = YW'(h);
    req_color[k*CW +: CW] = CW'(c);
  endtask

  task automatic wait_gnt(input string name, input int exp_idx);
    int n;
    int got;
    n = 0;
    do begin
      tick();
      n++;
    end while (gnt == '0 && n < 500);
    got = -1;
    for (int k = 0; k < N; k++) if (gnt[k]) got = k;
    check(name, 32'(got), 32'(exp_idx));
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    req = '0;
    do begin
      tick();
      n++;
    end while (busy && n < 2000);
    check("idle_timeout", 32'(busy), 32'd0);
  endtask

  task automatic rand_params();
    for (int k = 0; k < N; k++) begin
      set_par(k,
              ($urandom_range(1) == 0) ? $urandom_range(150, 255) : $urandom_range(0, 255),
              ($urandom_range(1) == 0) ? $urandom_range(112, 127) : $urandom_range(0, 127),
              $urandom_range(0, 10), $urandom_range(0, 5), $urandom_range(0, 7));
    end
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed + random stimulus ----------------
  initial begin : stim
    int n_draw, n_plot;
    int px[2];
    int py[2];
    resetn    = 1'b0;
    req       = '0;
    req_x     = '0;
    req_y     = '0;
    req_w     = '0;
    req_h     = '0;
    req_color = '0;
    #12;
    check("reset_outputs", {gnt, done, busy, vga_plot, vga_x, vga_y, vga_colour}, 32'd0);
    do_reset();

    // Single 2x2 rectangle from requester 1
    auto_drop = 1'b1;
    set_par(1, 10, 5, 2, 2, 4);
    req = 3'b010;
    tick();
    check("t1_gnt", 32'(gnt), 32'b010);
    check("t1_busy", 32'(busy), 32'd1);
    tick(); check("t1_p0", {vga_plot, vga_colour, vga_x, vga_y}, {20'd0, 1'b1, 3'd4, 8'd10, 7'd5});
    tick(); check("t1_p1", {vga_plot, vga_colour, vga_x, vga_y}, {20'd0, 1'b1, 3'd4, 8'd11, 7'd5});
    tick(); check("t1_p2", {vga_plot, vga_colour, vga_x, vga_y}, {20'd0, 1'b1, 3'd4, 8'd10, 7'd6});
    tick(); check("t1_p3", {vga_plot, vga_colour, vga_x, vga_y}, {20'd0, 1'b1, 3'd4, 8'd11, 7'd6});
    tick();
    check("t1_done", 32'(done), 32'b010);
    check("t1_done_plot", 32'(vga_plot), 32'd0);
    tick();
    check("t1_idle", {done, busy}, 32'd0);

    // Requesters 0 and 2 together, each dropping on its grant
    do_reset();
    set_par(0, 1, 1, 1, 1, 1);
    set_par(2, 2, 2, 1, 1, 2);
    req = 3'b101;
`ifdef VGA_DRAW_ARB_FIXED_PRIO_EN
    wait_gnt("t2_first", 0);
    wait_gnt("t2_second", 2);
`else
    wait_gnt("t2_first", 0);
    wait_gnt("t2_second", 2);
`endif
    wait_idle();

    // All three held continuously
    do_reset();
    auto_drop = 1'b0;
    set_par(1, 3, 3, 1, 1, 3);
    req = 3'b111;
`ifdef VGA_DRAW_ARB_FIXED_PRIO_EN
    wait_gnt("t2b_g0", 0);
    wait_gnt("t2b_g1", 0);
    wait_gnt("t2b_g2", 0);
    wait_gnt("t2b_g3", 0);
`else
    wait_gnt("t2b_g0", 0);
    wait_gnt("t2b_g1", 1);
    wait_gnt("t2b_g2", 2);
    wait_gnt("t2b_g3", 0);
`endif
    wait_idle();

    // Clipping at the bottom-right corner
    auto_drop = 1'b1;
    set_par(0, 158, 119, 4, 2, 1);
    req = 3'b001;
    wait_gnt("t3_gnt", 0);
    n_draw = 0;
    n_plot = 0;
    px = '{0, 0};
    py = '{0, 0};
    for (int c = 0; c < 100; c++) begin
      tick();
      if (done != '0) break;
      n_draw++;
      if (vga_plot) begin
        if (n_plot < 2) begin
          px[n_plot] = int'(vga_x);
          py[n_plot] = int'(vga_y);
        end
        n_plot++;
      end
    end
    check("t3_draw_cycles", 32'(n_draw), 32'd8);
    check("t3_plots", 32'(n_plot), 32'd2);
    check("t3_first", {16'(px[0]), 16'(py[0])}, {16'd158, 16'd119});
    check("t3_second", {16'(px[1]), 16'(py[1])}, {16'd159, 16'd119});
    wait_idle();

    // Zero-width rectangle
    set_par(2, 5, 5, 0, 5, 7);
    req = 3'b100;
    wait_gnt("t4_gnt", 2);
    check("t4_gnt_plot", 32'(vga_plot), 32'd0);
    tick();
    check("t4_done", 32'(done), 32'b100);
    check("t4_done_plot", 32'(vga_plot), 32'd0);
    tick();
    check("t4_idle", 32'(busy), 32'd0);

    // Reset on the 3rd pixel of a 4x4 draw
    set_par(0, 20, 20, 4, 4, 5);
    req = 3'b001;
    wait_gnt("t5_gnt", 0);
    tick();
    tick();
    tick();
    check("t5_pix3_plot", 32'(vga_plot), 32'd1);
    #1 resetn = 1'b0;
    #1 check("t5_async_clear", {gnt, done, busy, vga_plot, vga_x, vga_y, vga_colour}, 32'd0);
    repeat (2) begin
      @(posedge clk);
      #1 check("t5_no_done", 32'(done), 32'd0);
    end
    #1 resetn = 1'b1;
    set_par(2, 30, 30, 1, 1, 6);
    req = 3'b101;
    wait_gnt("t5_after_reset", 0);
    wait_idle();

    // Requesters 0 and 1 held, then 0 drops
    auto_drop = 1'b0;
    set_par(0, 0, 0, 1, 1, 1);
    set_par(1, 1, 0, 1, 1, 2);
    req = 3'b011;
`ifdef VGA_DRAW_ARB_FIXED_PRIO_EN
    wait_gnt("t6_g0", 0);
    wait_gnt("t6_g1", 0);
    wait_gnt("t6_g2", 0);
`else
    wait_gnt("t6_g0", 1);
    wait_gnt("t6_g1", 0);
    wait_gnt("t6_g2", 1);
`endif
    req = 3'b010;
    wait_gnt("t6_after_drop", 1);
    wait_idle();

    // Random traffic; the model checks every cycle
    rand_params();
    for (int n = 0; n < 3000; n++) begin
      tick();
      if (!resetn) resetn = 1'b1;
      for (int k = 0; k < N; k++) begin
        if (gnt[k] && $urandom_range(7) != 0) req[k] = 1'b0;
        if (!req[k] && $urandom_range(15) == 0) req[k] = 1'b1;
      end
      if ($urandom_range(3) == 0) rand_params();
      if ($urandom_range(599) == 0) resetn = 1'b0;
    end
    resetn = 1'b1;
    wait_idle();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_draw_arbiter.md
# vga_draw_arbiter

Shares the single pixel-write port of the 160x120 VGA adapter between several rectangle-drawing requesters: background clear, player sprite, enemy sprites and score. It accepts one rectangle request at a time, chosen by a round-robin arbiter. It then sweeps the rectangle row by row, emitting one pixel per clock on the adapter's x/y/colour/plot inputs. It sits between the game-logic FSMs and the adapter, replacing ad-hoc per-object plot muxing.

## Interface
- N_REQ, 3: number of requesters.
- X_W, 8: x coordinate / width bits.
- Y_W, 7: y coordinate / height bits.
- COLOR_W, 3: colour bits.
- clk  in  1  system clock (50 MHz).
- resetn  in  1  asynchronous, active-low reset.
- req  in  N_REQ  per-requester draw request, level; hold until gnt.
- req_x  in  N_REQ*X_W  top-left x, requester k at slice [k*X_W +: X_W].
- req_y  in  N_REQ*Y_W  top-left y.
- req_w  in  N_REQ*X_W  width in pixels (0 allowed).
- req_h  in  N_REQ*Y_W  height in pixels (0 allowed).
- req_color  in  N_REQ*COLOR_W  fill colour.
- gnt  out  N_REQ  one-hot, one-cycle pulse: request accepted, parameters latched.
- done  out  N_REQ  one-hot, one-cycle pulse: rectangle finished.
- busy  out  1  high in any state other than IDLE.
- vga_x  out  X_W  pixel x to adapter.
- vga_y  out  Y_W  pixel y to adapter.
- vga_colour  out  COLOR_W  pixel colour.
- vga_plot  out  1  write enable to adapter.

## Operation
- States: IDLE, LOAD, DRAW, DONE. All outputs are registered and reset to 0. Reset puts the FSM in IDLE and sets the RR pointer to N_REQ-1, so requester 0 wins first.
- IDLE:
  - If any req bit is high, the winner k is the first set bit searching from pointer+1 modulo N_REQ.
  - The requester's x, y, w, h and colour are latched at the edge.
  - The pointer is set to k and the FSM goes to LOAD.
- LOAD (1 cycle): gnt[k]=1, busy=1. Column counter i and row counter j are cleared.
  - If w==0 or h==0, next state is DONE.
  - Otherwise, next state is DRAW, with pixel (x0,y0) loaded into the vga_* registers.
- DRAW (w*h cycles): each cycle presents pixel (x0+i, y0+j) with vga_colour equal to the latched colour.
  - i increments each cycle. At i==w-1, i wraps to 0 and j increments.
  - When the presented pixel is (w-1, h-1), next state is DONE.
- Clipping:
  - Sums are computed at X_W+1 and Y_W+1 bits.
  - vga_plot=1 only if x0+i<160 and y0+j<120; otherwise vga_plot=0.
  - Clipped pixels still consume their cycle.
  - vga_x and vga_y carry the truncated sum.
- DONE (1 cycle): done[k]=1, vga_plot=0, then IDLE.
- A req still high in IDLE after done is a new request. Requesters drop req on gnt to avoid a redraw.
- req changes during LOAD, DRAW or DONE are ignored. Latched parameters are immune to later input changes.
- Reset mid-operation aborts the draw: no done pulse, and plot goes low immediately (asynchronous).

## Timing
- Clock k-1 (IDLE, req seen) → gnt on cycle k → first pixel on cycle k+1 → done on cycle k+1+w*h → IDLE on cycle k+2+w*h.
- Zero-area request: gnt, then done on the next cycle. Occupancy is 3 cycles including IDLE.
- Back-to-back: the IDLE cycle is mandatory between rectangles. Throughput is one pixel per clock in DRAW.

## Configuration
- VGA_DRAW_ARB_FIXED_PRIO_EN:
  - Defined: fixed priority, lowest index wins. The pointer is unused, so the background clearer must be the highest index.
  - Undefined (default): round-robin as above.

## Structure
- Shared package draw_pkg:
  - SCREEN_W=160, SCREEN_H=120.
  - Coordinate and colour widths.
  - The state enum (IDLE, LOAD, DRAW, DONE).
- Sub-module rr_arbiter: takes req, pointer and the enable from the macro; returns a one-hot winner and its index. Purely combinational.
- Pixel counters and FSM live in the top module.

## Test plan
- Single req[1]: x=10, y=5, w=2, h=2, colour=3'b100 → gnt[1] for 1 cycle. Plots (10,5), (11,5), (10,6), (11,6) on 4 consecutive cycles. done[1] on the next cycle, busy low after.
- req[0] and req[2] raised together and each dropped on its gnt → 0 served then 2. With all three held continuously, grant order is 0, 1, 2, 0.
- x=158, w=4, y=119, h=2 → 8 DRAW cycles. Plot high only at (158,119) and (159,119).
- w=0, h=5 → gnt, then done on the next cycle, vga_plot never high.
- resetn low on the 3rd DRAW pixel of a 4x4 draw → all outputs 0 asynchronously, no done. After release, requester 0 wins the next grant.
- With VGA_DRAW_ARB_FIXED_PRIO_EN and req[0] and req[1] held → req[0] granted repeatedly. req[1] is granted only after req[0] drops.
